// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared widths for the fcpu execution cluster.
package fcpu_pkg;
    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int INSTR_W  = 8;
    localparam int CDB_W    = RSV_ID_W + DATA_W;
endpackage

// File: rtl/reservation_station_ooo.sv
// reservation_station_ooo: out-of-order reservation station with CDB wakeup and oldest-first locked issue.
// Define RS_OCCUPANCY_EN to add the o_count / o_almost_full occupancy outputs.
module reservation_station_ooo
    import fcpu_pkg::*;
#(
    parameter int N_OPERANDS  = 2,
    parameter int N_ENTRIES_W = 3,
    parameter int N_CDB       = 2
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic                                         i_valid,
    input  logic [RSV_ID_W+INSTR_W+N_OPERANDS*CDB_W-1:0] i_data,
    input  logic [N_OPERANDS-1:0]                        i_filled,
    output logic                                         i_ready,
    output logic                                         o_valid,
    output logic [RSV_ID_W+INSTR_W+N_OPERANDS*DATA_W-1:0] o_data,
    input  logic                                         o_ready,
    input  logic [N_CDB-1:0]                             cdb_valid,
    input  logic [N_CDB*CDB_W-1:0]                       cdb,
    input  logic                                         i_flush
`ifdef RS_OCCUPANCY_EN
    ,
    output logic [N_ENTRIES_W:0]                         o_count,
    output logic                                         o_almost_full
`endif
);
    localparam int N_ENT = 1 << N_ENTRIES_W;
    localparam int HDR_W = RSV_ID_W + INSTR_W;

    logic [N_ENT-1:0]                             valid_q, valid_d;
    logic [N_ENT-1:0][N_OPERANDS-1:0]             filled_q, filled_d;
    logic [N_ENT-1:0][N_OPERANDS-1:0][CDB_W-1:0]  op_q, op_d;
    logic [N_ENT-1:0][HDR_W-1:0]                  hdr_q, hdr_d;
    logic [N_ENT-1:0][N_ENT-1:0]                  age_q, age_d;
    logic                                         lock_q, lock_d;
    logic [N_ENTRIES_W-1:0]                       lock_idx_q, lock_idx_d;
    logic [N_ENT-1:0]                             cand, sel_oh;
    logic [N_ENTRIES_W-1:0]                       sel_idx, free_idx;
    logic                                         issue, alloc;

    // Returns {filled, tag, data}; an unfilled operand takes the lowest matching lane's data.
    function automatic logic [CDB_W:0] snoop(input logic f, input logic [CDB_W-1:0] op,
                                             input logic [N_CDB-1:0] v, input logic [N_CDB*CDB_W-1:0] bus);
        snoop = {f, op};
        for (int l = N_CDB - 1; l >= 0; l--)
            if (!f && v[l] && bus[l*CDB_W+DATA_W +: RSV_ID_W] == op[DATA_W +: RSV_ID_W])
                snoop = {1'b1, op[DATA_W +: RSV_ID_W], bus[l*CDB_W +: DATA_W]};
    endfunction

    // age_q[j][i] set means entry j is older than entry i.
    always_comb begin
        cand     = '0;
        sel_oh   = '0;
        sel_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < N_ENT; i++) cand[i] = valid_q[i] && &filled_q[i];
        for (int i = 0; i < N_ENT; i++) begin
            sel_oh[i] = cand[i];
            for (int j = 0; j < N_ENT; j++) if (cand[j] && age_q[j][i]) sel_oh[i] = 1'b0;
        end
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (sel_oh[i]) sel_idx = N_ENTRIES_W'(i);
            if (!valid_q[i]) free_idx = N_ENTRIES_W'(i);
        end
        if (lock_q) sel_idx = lock_idx_q;
    end

    assign i_ready = !nrst && |(~valid_q);
    assign o_valid = !nrst && (lock_q || |cand);
    assign issue   = o_valid && o_ready && !i_flush;
    assign alloc   = i_valid && i_ready && !i_flush;

    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_OPERANDS; k++) o_data[k*DATA_W +: DATA_W] = op_q[sel_idx][k][DATA_W-1:0];
        o_data[N_OPERANDS*DATA_W +: HDR_W] = hdr_q[sel_idx];
        o_data = o_valid ? o_data : '0;
    end

    always_comb begin
        valid_d    = valid_q;
        filled_d   = filled_q;
        op_d       = op_q;
        hdr_d      = hdr_q;
        age_d      = age_q;
        lock_d     = o_valid && !o_ready;
        lock_idx_d = sel_idx;
        for (int i = 0; i < N_ENT; i++)
            for (int k = 0; k < N_OPERANDS; k++)
                {filled_d[i][k], op_d[i][k]} = snoop(filled_q[i][k], op_q[i][k], cdb_valid, cdb);
        if (issue) valid_d[sel_idx] = 1'b0;
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            hdr_d[free_idx]   = i_data[N_OPERANDS*CDB_W +: HDR_W];
            age_d[free_idx]   = '0;
            for (int k = 0; k < N_OPERANDS; k++)
                {filled_d[free_idx][k], op_d[free_idx][k]} = snoop(i_filled[k], i_data[k*CDB_W +: CDB_W], cdb_valid, cdb);
            for (int j = 0; j < N_ENT; j++) age_d[j][free_idx] = valid_q[j];
        end
    end

    always_ff @(posedge clk) begin
        if (nrst || i_flush) begin
            valid_q    <= '0;
            age_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            valid_q    <= valid_d;
            age_q      <= age_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
        filled_q <= filled_d;
        op_q     <= op_d;
        hdr_q    <= hdr_d;
    end

`ifdef RS_OCCUPANCY_EN
    logic [N_ENTRIES_W:0] count_q;

    always_ff @(posedge clk)
        count_q <= (nrst || i_flush) ? '0 : count_q + (N_ENTRIES_W+1)'(alloc) - (N_ENTRIES_W+1)'(issue);

    assign o_count       = count_q;
    assign o_almost_full = count_q >= (N_ENTRIES_W+1)'(N_ENT - 1);
`endif
endmodule

// File: tb/tb_reservation_station_ooo.sv
// tb_reservation_station_ooo: directed self-checking bench for reservation_station_ooo.
module tb_reservation_station_ooo;
    import fcpu_pkg::*;
    localparam int IN_W  = RSV_ID_W + INSTR_W + 2*CDB_W;
    localparam int OUT_W = RSV_ID_W + INSTR_W + 2*DATA_W;

    logic             clk = 1'b0;
    logic             nrst, i_valid, i_ready, o_valid, o_ready, i_flush;
    logic [IN_W-1:0]  i_data;
    logic [1:0]       i_filled, cdb_valid;
    logic [OUT_W-1:0] o_data;
    logic [2*CDB_W-1:0] cdb;
`ifdef RS_OCCUPANCY_EN
    logic [3:0]       o_count;
    logic             o_almost_full;
`endif
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reservation_station_ooo dut (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_data(i_data), .i_filled(i_filled),
        .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
        .cdb_valid(cdb_valid), .cdb(cdb), .i_flush(i_flush)
`ifdef RS_OCCUPANCY_EN
        , .o_count(o_count), .o_almost_full(o_almost_full)
`endif
    );

    function automatic logic [IN_W-1:0] mk(input logic [3:0] dest, input logic [7:0] instr,
                                           input logic [3:0] t1, input logic [15:0] d1,
                                           input logic [3:0] t0, input logic [15:0] d0);
        mk = {dest, instr, t1, d1, t0, d0};
    endfunction

    function automatic logic [OUT_W-1:0] ex(input logic [3:0] dest, input logic [7:0] instr,
                                            input logic [15:0] d1, input logic [15:0] d0);
        ex = {dest, instr, d1, d0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b1; i_valid = 1'b0; i_data = '0; i_filled = 2'b00; o_ready = 1'b0;
        cdb_valid = 2'b00; cdb = '0; i_flush = 1'b0;
        tick();
        i_valid = 1'b1; i_filled = 2'b11; o_ready = 1'b1;
        i_data = mk(4'd15, 8'hFF, 4'd0, 16'h0, 4'd0, 16'h0);
        #1;
        chk("rst_i_ready", i_ready, 1'b0);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_data", o_data, '0);
        tick();
        nrst = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        #1;
        chk("post_rst_i_ready", i_ready, 1'b1);
        chk("post_rst_o_valid", o_valid, 1'b0);

        // Fill all eight entries, then drain in dispatch order.
        for (int d = 0; d < 8; d++) begin
            i_valid = 1'b1; i_filled = 2'b11;
            i_data = mk(4'(d), 8'(8'h10 + d), 4'd0, 16'(16'h200 + d), 4'd0, 16'(16'h100 + d));
            #1;
            chk("t1_ready", i_ready, 1'b1);
            tick();
        end
        i_valid = 1'b0;
        #1;
        chk("t1_full", i_ready, 1'b0);
        chk("t1_o_valid", o_valid, 1'b1);
        o_ready = 1'b1;
        for (int d = 0; d < 8; d++) begin
            #1;
            chk("t1_issue", o_data, ex(4'(d), 8'(8'h10 + d), 16'(16'h200 + d), 16'(16'h100 + d)));
            tick();
        end
        o_ready = 1'b0;
        #1;
        chk("t1_empty_valid", o_valid, 1'b0);
        chk("t1_empty_data", o_data, '0);
        chk("t1_empty_ready", i_ready, 1'b1);

        // A waits on tag 3, B is ready: B first, A after its lane1 wakeup.
        o_ready = 1'b1; i_valid = 1'b1; i_filled = 2'b10;
        i_data = mk(4'd8, 8'hA0, 4'd0, 16'h1A1A, 4'd3, 16'h1111);
        tick();
        i_filled = 2'b11;
        i_data = mk(4'd9, 8'hB0, 4'd0, 16'h2B2B, 4'd0, 16'h2222);
        #1;
        chk("t2_a_wait", o_valid, 1'b0);
        tick();
        i_valid = 1'b0;
        #1;
        chk("t2_b_first", o_data, ex(4'd9, 8'hB0, 16'h2B2B, 16'h2222));
        tick();
        cdb_valid = 2'b11; cdb = {4'd3, 16'hDEAD, 4'd7, 16'h7777};
        #1;
        chk("t2_wake_not_same_cycle", o_valid, 1'b0);
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("t2_a_woken", o_data, ex(4'd8, 8'hA0, 16'h1A1A, 16'hDEAD));
        tick();
        o_ready = 1'b0;
        #1;
        chk("t2_empty", o_valid, 1'b0);

        // Capture at dispatch; both lanes match and lane0 wins.
        i_valid = 1'b1; i_filled = 2'b10;
        i_data = mk(4'd10, 8'hC0, 4'd0, 16'h3C3C, 4'd5, 16'h0000);
        cdb_valid = 2'b11; cdb = {4'd5, 16'hCAFE, 4'd5, 16'hBEEF};
        #1;
        chk("t3_not_yet", o_valid, 1'b0);
        tick();
        i_valid = 1'b0; cdb_valid = 2'b00;
        #1;
        chk("t3_captured", o_data, ex(4'd10, 8'hC0, 16'h3C3C, 16'hBEEF));
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        #1;
        chk("t3_empty", o_valid, 1'b0);

        // Younger E stalls locked while older D wakes up.
        i_valid = 1'b1; i_filled = 2'b10;
        i_data = mk(4'd11, 8'hD0, 4'd0, 16'h4D4D, 4'd6, 16'h0000);
        tick();
        i_filled = 2'b11;
        i_data = mk(4'd12, 8'hE0, 4'd0, 16'h5E5E, 4'd0, 16'h5555);
        tick();
        i_valid = 1'b0; cdb_valid = 2'b01; cdb = {20'h0, 4'd6, 16'h6666};
        #1;
        chk("t4_stall0", o_data, ex(4'd12, 8'hE0, 16'h5E5E, 16'h5555));
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("t4_stall1", o_data, ex(4'd12, 8'hE0, 16'h5E5E, 16'h5555));
        tick();
        chk("t4_stall2", o_data, ex(4'd12, 8'hE0, 16'h5E5E, 16'h5555));
        tick();
        o_ready = 1'b1;
        #1;
        chk("t4_younger_issue", o_data, ex(4'd12, 8'hE0, 16'h5E5E, 16'h5555));
        tick();
        chk("t4_older_issue", o_data, ex(4'd11, 8'hD0, 16'h4D4D, 16'h6666));
        tick();
        o_ready = 1'b0;
        #1;
        chk("t4_empty", o_valid, 1'b0);

        // Flush with five entries, a dispatch and an issue handshake all dropped.
        for (int d = 1; d <= 5; d++) begin
            i_valid = 1'b1; i_filled = 2'b11;
            i_data = mk(4'(d), 8'h50, 4'd0, 16'h0, 4'd0, 16'(16'h500 + d));
            tick();
        end
        i_flush = 1'b1; o_ready = 1'b1;
        i_data = mk(4'd6, 8'h50, 4'd0, 16'h0, 4'd0, 16'h0506);
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        #1;
        chk("t5_flush_o_valid", o_valid, 1'b0);
        chk("t5_flush_i_ready", i_ready, 1'b1);
`ifdef RS_OCCUPANCY_EN
        chk("t5_flush_count", o_count, 4'd0);
`endif
        tick();
        tick();
        chk("t5_still_empty", o_valid, 1'b0);
        i_valid = 1'b1; i_filled = 2'b11;
        i_data = mk(4'd13, 8'h5D, 4'd0, 16'h0D0D, 4'd0, 16'hD0D0);
        tick();
        i_valid = 1'b0;
        #1;
        chk("t5_fresh_issue", o_data, ex(4'd13, 8'h5D, 16'h0D0D, 16'hD0D0));
        tick();
        o_ready = 1'b0;
        #1;
        chk("t5_empty", o_valid, 1'b0);

        // Full station: same-cycle issue does not admit the dispatch until next cycle.
        for (int d = 0; d < 8; d++) begin
            i_valid = 1'b1; i_filled = 2'b11;
            i_data = mk(4'(d), 8'(8'h20 + d), 4'd0, 16'h0, 4'd0, 16'(16'h300 + d));
            tick();
        end
        o_ready = 1'b1;
        i_data = mk(4'd14, 8'h2E, 4'd0, 16'h0, 4'd0, 16'h03EE);
        #1;
        chk("t6_full_ready", i_ready, 1'b0);
        chk("t6_issue0", o_data, ex(4'd0, 8'h20, 16'h0, 16'h0300));
`ifdef RS_OCCUPANCY_EN
        chk("t6_count", o_count, 4'd8);
        chk("t6_almost_full", o_almost_full, 1'b1);
`endif
        tick();
        o_ready = 1'b0;
        #1;
        chk("t6_ready_after", i_ready, 1'b1);
        tick();
        i_valid = 1'b0; o_ready = 1'b1;
        for (int d = 1; d < 8; d++) begin
            #1;
            chk("t6_drain", o_data, ex(4'(d), 8'(8'h20 + d), 16'h0, 16'(16'h300 + d)));
            tick();
        end
        chk("t6_late_dispatch", o_data, ex(4'd14, 8'h2E, 16'h0, 16'h03EE));
        tick();
        o_ready = 1'b0;
        #1;
        chk("t6_empty", o_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
